// File: rtl/md_hilo_ctrl_if.sv
// EX-stage HI/LO bundle: instruction operands and products in, stall/status and HI/LO out,
// plus the handshake to the external pipelined unsigned divider.
interface md_hilo_ctrl_if;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic [31:0] mul_hi;
   logic [31:0] mul_lo;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_ena;
   logic [31:0] div_opa;
   logic [31:0] div_opb;
   logic        stall_ex;
   logic        busy;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport slave (
      input  op_valid, op_code, op_a, op_b, flush, mul_hi, mul_lo, div_q, div_r,
      output div_ena, div_opa, div_opb, stall_ex, busy, div_by_zero, hi, lo
   );

   modport master (
      output op_valid, op_code, op_a, op_b, flush, mul_hi, mul_lo, div_q, div_r,
      input  div_ena, div_opa, div_opb, stall_ex, busy, div_by_zero, hi, lo
   );
endinterface

// File: rtl/md_hilo_ctrl.sv
// HI/LO register owner for EX: single-cycle MULT/MTHI/MTLO, multi-cycle signed/unsigned
// divide sequenced around an external fixed-latency unsigned divider.
module md_hilo_ctrl #(
   parameter int DIV_LATENCY = 33
) (
   input logic            clk,
   input logic            rst,
   md_hilo_ctrl_if.slave  bus
);

   localparam int CW = $clog2(DIV_LATENCY + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   opa_q, opa_d;
   logic [31:0]   opb_q, opb_d;
   logic          q_neg_q, q_neg_d;
   logic          r_neg_q, r_neg_d;

   logic          issue;
   logic          is_mul;
   logic          is_div_any;
   logic          is_signed;
   logic          launch;
   logic          div_zero;
   logic [31:0]   abs_a, abs_b;
   logic [31:0]   q_fix, r_fix;

   // Operand decode; issue is only meaningful in IDLE, so DIV_DONE never relaunches.
   always_comb begin
      issue      = bus.op_valid && !bus.flush && (state_q == IDLE);
      is_mul     = (bus.op_code == OP_MULT) || (bus.op_code == OP_MULTU);
      is_div_any = (bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU);
      is_signed  = (bus.op_code == OP_DIV);
      launch     = issue && is_div_any && (bus.op_b != 32'd0);
      div_zero   = issue && is_div_any && (bus.op_b == 32'd0);
      abs_a      = (is_signed && bus.op_a[31]) ? (32'd0 - bus.op_a) : bus.op_a;
      abs_b      = (is_signed && bus.op_b[31]) ? (32'd0 - bus.op_b) : bus.op_b;
      q_fix      = q_neg_q ? (32'd0 - bus.div_q) : bus.div_q;
      r_fix      = r_neg_q ? (32'd0 - bus.div_r) : bus.div_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      if (bus.flush) begin
         // A flush kills everything, including a same-cycle MULT/MT* write.
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue) begin
                  if (is_mul) begin
                     hi_d = bus.mul_hi;
                     lo_d = bus.mul_lo;
                  end else if (bus.op_code == OP_MTHI) begin
                     hi_d = bus.op_a;
                  end else if (bus.op_code == OP_MTLO) begin
                     lo_d = bus.op_a;
                  end else if (launch) begin
                     opa_d   = abs_a;
                     opb_d   = abs_b;
                     q_neg_d = is_signed && (bus.op_a[31] ^ bus.op_b[31]);
                     r_neg_d = is_signed && bus.op_a[31];
                     cnt_d   = CW'(DIV_LATENCY);
                     state_d = DIV_RUN;
                  end
               end
            end
            DIV_RUN: begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  lo_d    = q_fix;
                  hi_d    = r_fix;
                  state_d = DIV_DONE;
               end
            end
            DIV_DONE: state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.stall_ex    = launch || ((state_q == DIV_RUN) && !bus.flush);
      bus.div_ena     = (state_q == DIV_RUN) && !bus.flush;
      bus.busy        = (state_q != IDLE);
      bus.div_by_zero = div_zero;
      bus.div_opa     = opa_q;
      bus.div_opb     = opb_q;
      bus.hi          = hi_q;
      bus.lo          = lo_q;
   end

endmodule
